// File: rtl/oam_dma_pkg.sv
// Shared constants and state encoding for the sprite (OAM) DMA engine.
package oam_dma_pkg;

  localparam int unsigned REG_WIDTH       = 8;
  localparam int unsigned ADDR_WIDTH      = 16;
  localparam int unsigned OAM_BYTES       = 256;
  localparam int unsigned DMA_STATE_WIDTH = 3;

  localparam logic [ADDR_WIDTH-1:0] DMA_TRIG_ADDR = 16'h4014;

  localparam logic [DMA_STATE_WIDTH-1:0] DMA_ST_IDLE  = 3'd0;
  localparam logic [DMA_STATE_WIDTH-1:0] DMA_ST_HALT  = 3'd1;
  localparam logic [DMA_STATE_WIDTH-1:0] DMA_ST_ALIGN = 3'd2;
  localparam logic [DMA_STATE_WIDTH-1:0] DMA_ST_READ  = 3'd3;
  localparam logic [DMA_STATE_WIDTH-1:0] DMA_ST_WRITE = 3'd4;

  typedef enum logic [DMA_STATE_WIDTH-1:0] {
    ST_IDLE  = DMA_ST_IDLE,
    ST_HALT  = DMA_ST_HALT,
    ST_ALIGN = DMA_ST_ALIGN,
    ST_READ  = DMA_ST_READ,
    ST_WRITE = DMA_ST_WRITE
  } dma_state_e;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: a CPU write to TRIG_ADDR halts the CPU and copies one page of
// mem into OAM using the alternating read/write cadence (513/514 cycles).
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter int unsigned             PAGE_BYTES = OAM_BYTES,
  parameter logic [ADDR_WIDTH-1:0]   TRIG_ADDR  = DMA_TRIG_ADDR
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [REG_WIDTH-1:0]  cpu_din,
  input  logic [REG_WIDTH-1:0]  mem_dout,
  output logic                  cpu_halt,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic                  oam_we,
  output logic [7:0]            oam_addr,
  output logic [REG_WIDTH-1:0]  oam_din
);

  localparam logic [7:0] LAST_IDX = 8'(PAGE_BYTES - 1);

  dma_state_e            state_q, state_d;
  logic [7:0]            idx_q, idx_d;
  logic [REG_WIDTH-1:0]  page_q, page_d;
  logic                  phase_q;
  logic                  cpu_halt_q, cpu_halt_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  oam_we_q, oam_we_d;
  logic [7:0]            oam_addr_q, oam_addr_d;

  // Next state plus Moore outputs decoded from the next state, so the
  // registered outputs always match the state register.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    page_d     = page_q;
    cpu_halt_d = 1'b0;
    mem_addr_d = '0;
    oam_we_d   = 1'b0;
    oam_addr_d = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (cpu_we && (cpu_addr == TRIG_ADDR)) begin
          page_d  = cpu_din;
          idx_d   = '0;
          state_d = ST_HALT;
        end
      end
      ST_HALT:  state_d = phase_q ? ST_ALIGN : ST_READ;
      ST_ALIGN: state_d = ST_READ;
      ST_READ:  state_d = ST_WRITE;
      ST_WRITE: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = ST_READ;
        end
      end
      default:  state_d = ST_IDLE;
    endcase

    cpu_halt_d = (state_d != ST_IDLE);
    if (state_d == ST_READ) begin
      mem_addr_d = ADDR_WIDTH'({page_d, idx_d});
    end
    if (state_d == ST_WRITE) begin
      oam_we_d   = 1'b1;
      oam_addr_d = idx_d;
    end
  end

  // State, datapath and output registers; phase toggles every clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      page_q     <= '0;
      phase_q    <= 1'b0;
      cpu_halt_q <= 1'b0;
      mem_addr_q <= '0;
      oam_we_q   <= 1'b0;
      oam_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      page_q     <= page_d;
      phase_q    <= ~phase_q;
      cpu_halt_q <= cpu_halt_d;
      mem_addr_q <= mem_addr_d;
      oam_we_q   <= oam_we_d;
      oam_addr_q <= oam_addr_d;
    end
  end

  assign cpu_halt = cpu_halt_q;
  assign mem_addr = mem_addr_q;
  assign mem_we   = 1'b0;
  assign oam_we   = oam_we_q;
  assign oam_addr = oam_addr_q;
  // mem data arrives registered during WRITE; pass it straight to OAM.
  assign oam_din  = oam_we_q ? mem_dout : '0;

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: stimulus queues expected OAM writes, a
// monitor pops and compares on every oam_we strobe.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  mem_dout;
  logic        cpu_halt;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic        oam_we;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_din;

  oam_dma dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_din),
    .mem_dout (mem_dout),
    .cpu_halt (cpu_halt),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .oam_we   (oam_we),
    .oam_addr (oam_addr),
    .oam_din  (oam_din)
  );

  always #5 clk = ~clk;

  // mem contents: page 2 holds addr[7:0]^5A, other pages are also distinct.
  function automatic logic [7:0] mem_val(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'h02;
  endfunction

  // Registered mem read port.
  always @(posedge clk) mem_dout <= mem_val(mem_addr);

  int          vecs = 0;
  int          errs = 0;
  int          edges = 0;
  logic [31:0] sb[$];
  logic [15:0] prev_ma = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    edges++;
  endtask

  task automatic push_page(input logic [7:0] page);
    logic [15:0] ma;
    for (int k = 0; k < 256; k++) begin
      ma = {page, 8'(k)};
      sb.push_back({ma, 8'(k), mem_val(ma)});
    end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_we = 1'b1; cpu_addr = a; cpu_din = d;
    tick();
    cpu_we = 1'b0;
  endtask

  // One full transfer; optionally injects a CPU write during halt cycle inj_at.
  task automatic xfer(input string name, input logic [7:0] page, input bit odd,
                      input int inj_at, input logic [15:0] inj_a, input logic [7:0] inj_d);
    int n;
    logic [15:0] a2;
    logic we_seen;
    if (((edges + 1) % 2) != int'(odd)) tick();
    push_page(page);
    cpu_write(16'h4014, page);
    n = 0; a2 = 16'hxxxx; we_seen = 1'b0;
    while (cpu_halt && n < 1000) begin
      n++;
      if (n == 2) a2 = mem_addr;
      we_seen |= mem_we;
      if (n == inj_at) begin
        cpu_we = 1'b1; cpu_addr = inj_a; cpu_din = inj_d;
      end else begin
        cpu_we = 1'b0;
      end
      tick();
    end
    cpu_we = 1'b0;
    chk({name, " halt_len"}, 32'(n), odd ? 32'd514 : 32'd513);
    chk({name, " cycle2_mem_addr"}, 32'(a2), odd ? 32'h0 : 32'({page, 8'h00}));
    chk({name, " mem_we"}, 32'(we_seen), 32'd0);
    chk({name, " sb_drained"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    int n;
    logic hs;
    reset_n = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    fork
      begin : monitor
        forever begin
          @(negedge clk);
          if (oam_we) begin
            if (sb.size() == 0) begin
              chk("unexpected_oam_we", {prev_ma, oam_addr, oam_din}, 32'h0);
            end else begin
              chk("oam_write", {prev_ma, oam_addr, oam_din}, sb.pop_front());
            end
          end
          prev_ma = mem_addr;
        end
      end
      begin : stim
        #1;
        chk("reset_outputs", 32'({cpu_halt, mem_addr, mem_we, oam_we, oam_addr, oam_din}), 32'h0);
        tick(); tick();
        reset_n = 1'b1; edges = 0;

        // Non-trigger writes in IDLE
        hs = 1'b0;
        cpu_write(16'h4013, 8'h02); hs |= cpu_halt;
        cpu_write(16'h4015, 8'h02); hs |= cpu_halt;
        for (int i = 0; i < 4; i++) begin tick(); hs |= cpu_halt; end
        chk("nontrig_halt", 32'(hs), 32'd0);

        xfer("even",   8'h02, 1'b0, 0, 16'h0, 8'h0);
        xfer("odd",    8'h02, 1'b1, 0, 16'h0, 8'h0);
        xfer("retrig", 8'h02, 1'b0, 100, 16'h4014, 8'h03);
        xfer("page3",  8'h03, 1'b1, 50, 16'h4015, 8'h07);
        xfer("pageFF", 8'hFF, 1'b0, 513, 16'h4014, 8'h05);
        hs = 1'b0;
        for (int i = 0; i < 3; i++) begin tick(); hs |= cpu_halt; end
        chk("last_edge_trigger_ignored", 32'(hs), 32'd0);

        // Reset in the middle of the byte-40 WRITE cycle
        if ((edges + 1) % 2 != 0) tick();
        push_page(8'h02);
        cpu_write(16'h4014, 8'h02);
        n = 0;
        while (!(oam_we && oam_addr == 8'd40) && n < 600) begin n++; tick(); end
        chk("reach_byte40", 32'(oam_we && oam_addr == 8'd40), 32'd1);
        #2;
        sb.delete();
        reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({cpu_halt, mem_addr, mem_we, oam_we, oam_addr, oam_din}), 32'h0);
        tick(); tick();
        reset_n = 1'b1; edges = 0;
        // First edge after release is odd, so this trigger must align.
        xfer("post_reset", 8'h02, 1'b1, 0, 16'h0, 8'h0);
        tick();
      end
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
# oam_dma

Sprite DMA engine that sits directly upstream of the `mem` block on the CPU-side bus. A CPU write of page number P to address 16'h4014 halts the CPU and copies the 256 bytes at P*256..P*256+255 from `mem` into PPU OAM. It uses the NES read/write-alternating cadence and costs 513 or 514 cycles, depending on cycle parity.

## Interface
- `PAGE_BYTES`, 256: bytes per transfer; must be a power of two ≤ 256.
- `TRIG_ADDR`, 16'h4014: CPU write address that starts a transfer.
- `clk` input 1: system clock (phi0); all state changes on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `cpu_we` input 1: CPU write strobe.
- `cpu_addr` input `ADDR_WIDTH`: CPU address.
- `cpu_din` input `REG_WIDTH`: CPU write data; the page number on trigger.
- `mem_dout` input `REG_WIDTH`: `mem` read data, registered, valid the cycle after the address is presented.
- `cpu_halt` output 1: CPU stalled and bus owned by DMA.
- `mem_addr` output `ADDR_WIDTH`: DMA read address to `mem`; valid in READ.
- `mem_we` output 1: always 0. DMA never writes `mem`; the port exists for the bus mux.
- `oam_we` output 1: OAM write strobe.
- `oam_addr` output 8: OAM byte index.
- `oam_din` output `REG_WIDTH`: OAM write data.

## Operation
- States: IDLE, HALT, ALIGN, READ, WRITE.
- **Trigger:** `cpu_we` && `cpu_addr` == `TRIG_ADDR` while in IDLE.
  - Latch `page` <= `cpu_din`, `idx` <= 0, go to HALT.
- **HALT** (1 cycle): go to ALIGN if `phase` == 1, else READ.
- **ALIGN** (1 cycle): go to READ.
- **READ:** `mem_addr` = {`page`, `idx`}; go to WRITE.
- **WRITE:**
  - Drive `oam_we` = 1, `oam_addr` = `idx`, `oam_din` = `mem_dout` (combinational pass-through).
  - If `idx` == `PAGE_BYTES`-1, go to IDLE; else `idx` += 1 and go to READ.
- **Phase flop:** `phase` toggles every clock; reset value 0, so the first cycle after reset is even.
- `cpu_halt` = 1 in every state except IDLE.
- **Moore outputs:** outputs are decoded from the state register only, except `oam_din`.
  - Outside READ, `mem_addr` = 0.
  - Outside WRITE, `oam_we` = 0, `oam_addr` = 0, `oam_din` = 0.
- **Width rules:**
  - `idx` is 8 bits and wraps after 255 without overflow into `page`.
  - `mem_addr` upper byte is `page`; `page` above the `mem` depth wraps inside `mem`, not here.
- **Boundary cases:**
  - A trigger write while not IDLE is ignored: `page` is unchanged and the transfer is not restarted.
  - A write to any address other than `TRIG_ADDR` has no effect in any state.
  - A trigger in the same edge that returns to IDLE (the last WRITE) is ignored. The trigger is sampled only in IDLE.
  - **Reset mid-transfer:** on `reset_n` low, the block goes to IDLE immediately and asynchronously. All outputs go to 0, `idx` = 0, `page` = 0, `phase` = 0. No partial-restart state is retained.

## Timing
- Reset value of every output is 0: `cpu_halt`, `mem_addr`, `mem_we`, `oam_we`, `oam_addr`, `oam_din`.
- Trigger sampled at edge T0; `cpu_halt` rises after T0.
- Even case (`phase` == 0 in HALT):
  - HALT at cycle 1, READ/WRITE pairs at cycles 2..513.
  - `cpu_halt` is high for 513 cycles.
- Odd case: ALIGN inserted; `cpu_halt` is high for 514 cycles.
- Byte k: READ at cycle 2+2k(+1 if aligned); OAM write committed at the end of the following WRITE cycle.
- Latency from the byte k `mem_addr` to its OAM write strobe is one cycle.

## Structure
- Shared package `PKG/pkg.v` gains:
  - `DMA_TRIG_ADDR` (16'h4014)
  - `OAM_BYTES` (256)
  - `DMA_STATE_WIDTH` (3) and the five state encodings as localparams
- `REG_WIDTH` and `ADDR_WIDTH` are reused from the package.
- Single module, no sub-module: one FSM plus the `idx`, `page` and `phase` registers.
- Bus muxing between CPU and DMA stays at the top level, selected by `cpu_halt`.

## Test plan
- **Even-phase transfer:** preload `mem` page 2 with data = addr[7:0]^8'h5A. Trigger with `cpu_din` = 8'h02 on an even phase.
  - `cpu_halt` is high for exactly 513 cycles.
  - OAM[k] = k^8'h5A for k = 0..255.
  - `mem_addr` sequence is 16'h0200..16'h02FF.
- **Odd-phase transfer:** same stimulus, triggered one cycle later.
  - ALIGN is observed; `cpu_halt` is high for 514 cycles.
  - OAM contents are identical to the even case.
- **Ignored re-trigger:** write 8'h03 to 16'h4014 at cycle 100 of a page-2 transfer.
  - The transfer still reads 16'h02xx only and ends at the original cycle.
  - A subsequent write in IDLE starts a page-3 transfer.
- **Non-trigger writes:** writes to 16'h4013 and 16'h4015 in IDLE.
  - `cpu_halt` stays 0 and no `oam_we` pulse occurs.
- **Reset mid-transfer:** assert `reset_n` = 0 mid-WRITE at byte 40.
  - All outputs are 0 immediately, without waiting for an edge.
  - After release, the next trigger restarts at `oam_addr` 0 with `phase` starting even.
- **Page boundary:** trigger page 8'hFF.
  - The last `mem_addr` is 16'hFFFF; `idx` wraps with no spill.
  - `mem_we` is 0 throughout.
